// File: rtl/dallanma_ongoru_gshare.sv
// Gshare direction predictor with a tagged BTB: zero-latency lookup, resolved-branch update, GHR restore.
// Optional build macro DALLANMA_ISTATISTIK_EN adds saturating lookup/taken/mispredict counters.
module dallanma_ongoru_gshare #(
  parameter int BTB_BOYUTU      = 128,
  parameter int PHT_BOYUTU      = 256,
  parameter int GECMIS_UZUNLUGU = 8,
  parameter int SAYAC_GENISLIGI = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ongoru_aktif_i,
  input  logic [31:0]                ps_i,
  output logic [31:0]                atlanan_ps_o,
  output logic                       ongoru_gecerli_o,
  output logic [GECMIS_UZUNLUGU-1:0] ongoru_gecmis_o,
  input  logic                       guncelle_gecerli_i,
  input  logic                       guncelle_atladi_i,
  input  logic [31:0]                guncelle_ps_i,
  input  logic [31:0]                guncelle_hedef_adresi_i,
  input  logic [GECMIS_UZUNLUGU-1:0] guncelle_gecmis_i,
  input  logic                       dallanma_hata_i
`ifdef DALLANMA_ISTATISTIK_EN
  ,
  output logic [31:0]                tahmin_sayisi_o,
  output logic [31:0]                atlar_tahmin_sayisi_o,
  output logic [31:0]                hata_sayisi_o
`endif
);

  localparam int BIW  = $clog2(BTB_BOYUTU);
  localparam int PIW  = $clog2(PHT_BOYUTU);
  localparam int G    = GECMIS_UZUNLUGU;
  localparam int W    = SAYAC_GENISLIGI;
  localparam int TAGW = 31 - BIW;

  logic [G-1:0]         ghr_q, ghr_d;
  logic [W-1:0]         pht_q [PHT_BOYUTU];
  logic [BTB_BOYUTU-1:0] btb_gecerli_q;
  logic [TAGW-1:0]      btb_etiket_q [BTB_BOYUTU];
  logic [31:0]          btb_hedef_q  [BTB_BOYUTU];

  logic [PIW-1:0]  pidx, uidx;
  logic [BIW-1:0]  bidx, ubidx;
  logic [TAGW-1:0] etiket;
  logic            isabet;
  logic [W-1:0]    sayac_mevcut, sayac_yeni;
  logic            hata_gecerli;

  // Lookup path: purely combinational, sees pre-update table contents.
  assign pidx   = ps_i[PIW:1] ^ PIW'(ghr_q);
  assign bidx   = ps_i[BIW:1];
  assign etiket = ps_i[31:BIW+1];
  assign isabet = btb_gecerli_q[bidx] && (btb_etiket_q[bidx] == etiket);

  assign ongoru_gecerli_o = ongoru_aktif_i && isabet && pht_q[pidx][W-1];
  assign atlanan_ps_o     = ongoru_gecerli_o ? btb_hedef_q[bidx] : 32'd0;
  assign ongoru_gecmis_o  = ghr_q;

  assign uidx         = guncelle_ps_i[PIW:1] ^ PIW'(guncelle_gecmis_i);
  assign ubidx        = guncelle_ps_i[BIW:1];
  assign hata_gecerli = guncelle_gecerli_i && dallanma_hata_i;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sayac_mevcut = pht_q[uidx];
    sayac_yeni   = sayac_mevcut;
    if (guncelle_atladi_i) begin
      if (sayac_mevcut != {W{1'b1}}) sayac_yeni = sayac_mevcut + W'(1);
    end else begin
      if (sayac_mevcut != {W{1'b0}}) sayac_yeni = sayac_mevcut - W'(1);
    end
  end

  // Restore beats speculative shift; the (G+1)-bit concatenation truncates to the low G bits,
  // which also covers G=1.
  always_comb begin
    ghr_d = ghr_q;
    if (hata_gecerli)        ghr_d = G'({guncelle_gecmis_i, guncelle_atladi_i});
    else if (ongoru_aktif_i) ghr_d = G'({ghr_q, ongoru_gecerli_o});
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < PHT_BOYUTU; i++) pht_q[i] <= '0;
    end else if (guncelle_gecerli_i) begin
      pht_q[uidx] <= sayac_yeni;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      btb_gecerli_q <= '0;
    end else if (guncelle_gecerli_i && guncelle_atladi_i) begin
      btb_gecerli_q[ubidx] <= 1'b1;
    end
  end

  // NOTE: tag/target arrays carry no reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk_i) begin
    if (guncelle_gecerli_i && guncelle_atladi_i) begin
      btb_etiket_q[ubidx] <= guncelle_ps_i[31:BIW+1];
      btb_hedef_q[ubidx]  <= guncelle_hedef_adresi_i;
    end
  end

`ifdef DALLANMA_ISTATISTIK_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tahmin_sayisi_o       <= '0;
      atlar_tahmin_sayisi_o <= '0;
      hata_sayisi_o         <= '0;
    end else begin
      if (ongoru_aktif_i && tahmin_sayisi_o != 32'hFFFF_FFFF)
        tahmin_sayisi_o <= tahmin_sayisi_o + 32'd1;
      if (ongoru_gecerli_o && atlar_tahmin_sayisi_o != 32'hFFFF_FFFF)
        atlar_tahmin_sayisi_o <= atlar_tahmin_sayisi_o + 32'd1;
      if (hata_gecerli && hata_sayisi_o != 32'hFFFF_FFFF)
        hata_sayisi_o <= hata_sayisi_o + 32'd1;
    end
  end
`endif

  // Instruction addresses are halfword aligned; bit 0 never selects anything.
  logic unused_bits;
  assign unused_bits = ps_i[0] ^ guncelle_ps_i[0];

endmodule

// File: tb/tb_dallanma_ongoru_gshare.sv
// Self-checking bench for dallanma_ongoru_gshare against an arithmetic reference model.
`timescale 1ns/1ps
module tb_dallanma_ongoru_gshare;

  localparam int PHT = 256;
  localparam int BTB = 128;
  localparam int SAT = 3;   // 2^W - 1 for W = 2
  localparam int MSB = 2;   // counter value at which the MSB is set

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        ongoru_aktif_i = 1'b0;
  logic [31:0] ps_i = '0;
  logic [31:0] atlanan_ps_o;
  logic        ongoru_gecerli_o;
  logic [7:0]  ongoru_gecmis_o;
  logic        guncelle_gecerli_i = 1'b0;
  logic        guncelle_atladi_i = 1'b0;
  logic [31:0] guncelle_ps_i = '0;
  logic [31:0] guncelle_hedef_adresi_i = '0;
  logic [7:0]  guncelle_gecmis_i = '0;
  logic        dallanma_hata_i = 1'b0;
`ifdef DALLANMA_ISTATISTIK_EN
  logic [31:0] tahmin_sayisi_o, atlar_tahmin_sayisi_o, hata_sayisi_o;
  int unsigned m_tahmin, m_atlar, m_hata;
`endif

  always #5 clk_i = ~clk_i;

  dallanma_ongoru_gshare dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .ongoru_aktif_i          (ongoru_aktif_i),
    .ps_i                    (ps_i),
    .atlanan_ps_o            (atlanan_ps_o),
    .ongoru_gecerli_o        (ongoru_gecerli_o),
    .ongoru_gecmis_o         (ongoru_gecmis_o),
    .guncelle_gecerli_i      (guncelle_gecerli_i),
    .guncelle_atladi_i       (guncelle_atladi_i),
    .guncelle_ps_i           (guncelle_ps_i),
    .guncelle_hedef_adresi_i (guncelle_hedef_adresi_i),
    .guncelle_gecmis_i       (guncelle_gecmis_i),
    .dallanma_hata_i         (dallanma_hata_i)
`ifdef DALLANMA_ISTATISTIK_EN
    ,
    .tahmin_sayisi_o         (tahmin_sayisi_o),
    .atlar_tahmin_sayisi_o   (atlar_tahmin_sayisi_o),
    .hata_sayisi_o           (hata_sayisi_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: counters as integers, BTB as full PC + target per slot, GHR as an int.
  int          pht_m [PHT];
  bit          valid_m [BTB];
  logic [31:0] bpc_m [BTB];
  logic [31:0] btgt_m [BTB];
  int          ghr_m;

  logic        exp_vld, obs_vld;
  logic [31:0] exp_tgt, obs_tgt;
  logic [7:0]  exp_ghr, obs_ghr;

  logic [31:0] pool [8] = '{32'h100, 32'h300, 32'h1000, 32'h2040,
                            32'h5554, 32'hABC0, 32'h0180, 32'h7F02};

  task automatic model_clear();
    ghr_m = 0;
    foreach (pht_m[i]) pht_m[i] = 0;
    foreach (valid_m[i]) valid_m[i] = 1'b0;
`ifdef DALLANMA_ISTATISTIK_EN
    m_tahmin = 0; m_atlar = 0; m_hata = 0;
`endif
  endtask

  task automatic idle_inputs();
    ongoru_aktif_i = 0; ps_i = '0; guncelle_gecerli_i = 0; guncelle_atladi_i = 0;
    guncelle_ps_i = '0; guncelle_hedef_adresi_i = '0; guncelle_gecmis_i = '0; dallanma_hata_i = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    #2 rst_i = 1'b0;
    model_clear();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // One clock: drive, capture model expectation and DUT outputs mid-cycle, advance model at the edge.
  task automatic cycle(input bit aktif, input logic [31:0] ps, input bit upd, input bit atl,
                       input logic [31:0] ups, input logic [31:0] hedef,
                       input logic [7:0] gec, input bit hata);
    int p, b, u, ub;
    bit hit, pred;
    ongoru_aktif_i = aktif; ps_i = ps; guncelle_gecerli_i = upd; guncelle_atladi_i = atl;
    guncelle_ps_i = ups; guncelle_hedef_adresi_i = hedef; guncelle_gecmis_i = gec;
    dallanma_hata_i = hata;
    #2;
    p    = int'((ps >> 1) % PHT) ^ ghr_m;
    b    = int'((ps >> 1) % BTB);
    hit  = valid_m[b] && ((bpc_m[b] >> 8) == (ps >> 8));
    pred = aktif && hit && (pht_m[p] >= MSB);
    exp_vld = pred;
    exp_tgt = pred ? btgt_m[b] : 32'd0;
    exp_ghr = 8'(ghr_m);
    obs_vld = ongoru_gecerli_o; obs_tgt = atlanan_ps_o; obs_ghr = ongoru_gecmis_o;
    @(posedge clk_i);
`ifdef DALLANMA_ISTATISTIK_EN
    if (aktif) m_tahmin++;
    if (pred) m_atlar++;
    if (upd && hata) m_hata++;
`endif
    if (upd) begin
      u = int'((ups >> 1) % PHT) ^ int'(gec);
      if (atl) begin
        if (pht_m[u] < SAT) pht_m[u]++;
        ub = int'((ups >> 1) % BTB);
        valid_m[ub] = 1'b1; bpc_m[ub] = ups; btgt_m[ub] = hedef;
      end else if (pht_m[u] > 0) begin
        pht_m[u]--;
      end
    end
    if (upd && hata)  ghr_m = ((int'(gec) << 1) | int'(atl)) % 256;
    else if (aktif)   ghr_m = ((ghr_m << 1) | int'(pred)) % 256;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    cycle(1, 32'h100, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({obs_vld, obs_tgt, obs_ghr} !== {1'b0, 32'd0, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_lookup: got vld=%b tgt=%h ghr=%h, expected vld=0 tgt=0 ghr=00", obs_vld, obs_tgt, obs_ghr);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_ghr !== 8'h00) begin
      n_errors++; $display("FAIL reset_ghr_hold: got %h expected 00", obs_ghr);
    end
  endtask

  task automatic test_pht_train();
    cycle(0, 0, 1, 1, 32'h100, 32'h200, 8'h00, 0);
    cycle(0, 0, 1, 1, 32'h100, 32'h200, 8'h00, 0);
    cycle(1, 32'h100, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({obs_vld, obs_tgt} !== {1'b1, 32'h200} || {exp_vld, exp_tgt} !== {1'b1, 32'h200}) begin
      n_errors++; $display("FAIL train_lookup: got vld=%b tgt=%h expected vld=1 tgt=200", obs_vld, obs_tgt);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_ghr !== 8'h01) begin
      n_errors++; $display("FAIL train_ghr_shift: got %h expected 01", obs_ghr);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] g0;
    g0 = 8'(ghr_m);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, 32'h180, 32'h900, g0, 0);
    cycle(0, 0, 1, 0, 32'h180, 32'h900, g0, 0);
    cycle(1, 32'h180, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({obs_vld, obs_tgt} !== {1'b1, 32'h900}) begin
      n_errors++; $display("FAIL sat_still_taken: got vld=%b tgt=%h expected vld=1 tgt=900", obs_vld, obs_tgt);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 32'h180, 32'h900, g0, 0);
    // Mispredict restore on an unrelated PC puts the GHR back to g0.
    cycle(0, 0, 1, 1, 32'h1000, 32'h44, {1'b0, g0[7:1]}, 1);
    cycle(1, 32'h180, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({obs_vld, obs_tgt, obs_ghr} !== {1'b0, 32'd0, g0}) begin
      n_errors++; $display("FAIL sat_drained: got vld=%b tgt=%h ghr=%h expected vld=0 tgt=0 ghr=%h", obs_vld, obs_tgt, obs_ghr, g0);
    end
  endtask

  task automatic test_misp_restore();
    cycle(0, 0, 1, 0, 32'h2000, 0, 8'h2D, 1);
    cycle(1, 32'h100, 1, 1, 32'h2000, 32'h60, 8'h12, 1);
    n_checks++;
    if (obs_ghr !== 8'h5A) begin
      n_errors++; $display("FAIL restore_setup: got %h expected 5a", obs_ghr);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_ghr !== 8'h25) begin
      n_errors++; $display("FAIL restore_priority: got %h expected 25", obs_ghr);
    end
    // Mispredict flag without update valid must be ignored.
    cycle(0, 0, 0, 1, 32'h2000, 0, 8'hFF, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_ghr !== 8'h25) begin
      n_errors++; $display("FAIL restore_unqualified: got %h expected 25", obs_ghr);
    end
  endtask

  task automatic test_alias();
    cycle(0, 0, 1, 1, 32'h100, 32'h200, 8'(ghr_m), 0);
    cycle(0, 0, 1, 1, 32'h100, 32'h200, 8'(ghr_m), 0);
    cycle(0, 0, 1, 1, 32'h300, 32'h400, 8'(ghr_m), 0);
    cycle(1, 32'h100, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({obs_vld, obs_tgt} !== {1'b0, 32'd0}) begin
      n_errors++; $display("FAIL alias_evicted: got vld=%b tgt=%h expected vld=0 tgt=0", obs_vld, obs_tgt);
    end
    cycle(0, 0, 1, 1, 32'h300, 32'h400, 8'(ghr_m), 0);
    cycle(0, 0, 1, 1, 32'h300, 32'h400, 8'(ghr_m), 0);
    cycle(1, 32'h300, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({obs_vld, obs_tgt} !== {1'b1, 32'h400}) begin
      n_errors++; $display("FAIL alias_new_owner: got vld=%b tgt=%h expected vld=1 tgt=400", obs_vld, obs_tgt);
    end
  endtask

  task automatic test_random();
    bit hata, upd;
    logic [7:0] gec;
    for (int i = 0; i < 400; i++) begin
      upd  = ($urandom_range(1) == 1);
      hata = ($urandom_range(3) == 0);
      gec  = ($urandom_range(3) == 0) ? 8'($urandom) : 8'(ghr_m);
      cycle($urandom_range(1) == 1, pool[$urandom_range(7)], upd, $urandom_range(2) != 0,
            pool[$urandom_range(7)], $urandom, gec, hata);
      n_checks++;
      if ({obs_vld, obs_tgt, obs_ghr} !== {exp_vld, exp_tgt, exp_ghr}) begin
        n_errors++;
        $display("FAIL random[%0d]: got vld=%b tgt=%h ghr=%h expected vld=%b tgt=%h ghr=%h",
                 i, obs_vld, obs_tgt, obs_ghr, exp_vld, exp_tgt, exp_ghr);
      end
    end
`ifdef DALLANMA_ISTATISTIK_EN
    n_checks++;
    if ({tahmin_sayisi_o, atlar_tahmin_sayisi_o, hata_sayisi_o} !== {m_tahmin, m_atlar, m_hata}) begin
      n_errors++;
      $display("FAIL random_stats: got %0d/%0d/%0d expected %0d/%0d/%0d", tahmin_sayisi_o,
               atlar_tahmin_sayisi_o, hata_sayisi_o, m_tahmin, m_atlar, m_hata);
    end
`endif
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 1, 1, 32'h300, 32'h400, 8'h7F, 1);
    cycle(0, 0, 1, 1, 32'h300, 32'h400, 8'hFF, 0);
    ongoru_aktif_i = 1; ps_i = 32'h300; guncelle_gecerli_i = 0; dallanma_hata_i = 0;
    #3 rst_i = 1'b0;
    #1;
    n_checks++;
    if ({ongoru_gecmis_o, ongoru_gecerli_o, atlanan_ps_o} !== {8'h00, 1'b0, 32'd0}) begin
      n_errors++;
      $display("FAIL async_reset: got ghr=%h vld=%b tgt=%h expected ghr=00 vld=0 tgt=0",
               ongoru_gecmis_o, ongoru_gecerli_o, atlanan_ps_o);
    end
`ifdef DALLANMA_ISTATISTIK_EN
    n_checks++;
    if ({tahmin_sayisi_o, atlar_tahmin_sayisi_o, hata_sayisi_o} !== 96'd0) begin
      n_errors++; $display("FAIL async_reset_stats: got %0d/%0d/%0d expected 0/0/0",
                           tahmin_sayisi_o, atlar_tahmin_sayisi_o, hata_sayisi_o);
    end
`endif
    model_clear();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    cycle(1, 32'h300, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({obs_vld, obs_tgt, obs_ghr} !== {1'b0, 32'd0, 8'h00}) begin
      n_errors++; $display("FAIL post_reset_lookup: got vld=%b tgt=%h ghr=%h expected vld=0 tgt=0 ghr=00",
                           obs_vld, obs_tgt, obs_ghr);
    end
  endtask

`ifdef DALLANMA_ISTATISTIK_EN
  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 10; i++)
      cycle(1, pool[i % 8], i < 3, 1, pool[(i + 1) % 8], 32'h80, 8'(ghr_m), i < 3);
    n_checks++;
    if ({tahmin_sayisi_o, hata_sayisi_o, atlar_tahmin_sayisi_o} !== {32'd10, 32'd3, m_atlar}) begin
      n_errors++; $display("FAIL stats_counts: got %0d/%0d/%0d expected 10/3/%0d",
                           tahmin_sayisi_o, hata_sayisi_o, atlar_tahmin_sayisi_o, m_atlar);
    end
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_pht_train();
    test_saturation();
    test_misp_restore();
    test_alias();
    test_random();
    test_async_reset();
`ifdef DALLANMA_ISTATISTIK_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dallanma_ongoru_gshare.md
Name: dallanma_ongoru_gshare

Overview:
Parametrised gshare direction predictor with a tagged branch target buffer (BTB). It replaces the single-table bimodal predictor in the fetch stage and feeds the program counter generator with a predicted target. A speculative global history register (GHR) is XORed with the PC to index the pattern history table (PHT). The GHR is restored from the resolving stage on a misprediction.

Parameters:
BTB_BOYUTU, 128, BTB entries (power of 2); BIW = $clog2(BTB_BOYUTU)
PHT_BOYUTU, 256, PHT counters (power of 2); PIW = $clog2(PHT_BOYUTU)
GECMIS_UZUNLUGU, 8, GHR length G; legal range 1..PIW
SAYAC_GENISLIGI, 2, saturating counter width W; legal range 1..4

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
ongoru_aktif_i  input  1  predictor lookup request for ps_i (branch decoded)
ps_i  input  32  PC being fetched
atlanan_ps_o  output  32  predicted target; 0 when ongoru_gecerli_o=0
ongoru_gecerli_o  output  1  predicted taken with BTB hit
ongoru_gecmis_o  output  G  GHR value used for this lookup; carried down the pipe
guncelle_gecerli_i  input  1  resolved-branch update valid
guncelle_atladi_i  input  1  resolved branch was taken
guncelle_ps_i  input  32  PC of resolved branch
guncelle_hedef_adresi_i  input  32  resolved target
guncelle_gecmis_i  input  G  ongoru_gecmis_o captured at prediction time
dallanma_hata_i  input  1  misprediction; qualified by guncelle_gecerli_i

Behaviour:
- Reset (async, rst_i=0): GHR=0; every PHT counter=0 (strongly not-taken); all BTB valid bits=0. Tag and target arrays are not reset.
- Lookup is combinational in the same cycle, zero latency.
  - pidx = ps_i[PIW:1] XOR {zero-extend GHR to PIW}.
  - bidx = ps_i[BIW:1]; tag = ps_i[31:BIW+1].
  - hit = valid[bidx] and tag match.
  - Predicted taken = hit and MSB of PHT[pidx].
  - ongoru_gecerli_o = ongoru_aktif_i and hit and PHT[pidx] MSB; atlanan_ps_o = target[bidx] when valid, else 0.
  - ongoru_gecmis_o = current GHR.
- Update, on a clock edge with guncelle_gecerli_i=1:
  - uidx = guncelle_ps_i[PIW:1] XOR guncelle_gecmis_i (zero-extended).
  - PHT[uidx]: taken -> increment, saturating at 2^W-1; not-taken -> decrement, saturating at 0.
  - Taken: BTB[guncelle_ps_i[BIW:1]] gets valid=1, tag, and target, overwriting any alias.
  - Not-taken: BTB is unchanged.
- GHR next-state, in priority order:
  1. guncelle_gecerli_i and dallanma_hata_i: GHR <= {guncelle_gecmis_i[G-2:0], guncelle_atladi_i}. For G=1 this is guncelle_atladi_i. Any lookup shift in the same cycle is discarded.
  2. ongoru_aktif_i: GHR <= {GHR[G-2:0], ongoru_gecerli_o}.
  3. Otherwise hold.
- dallanma_hata_i without guncelle_gecerli_i is ignored.
- Lookup and update to the same PHT/BTB entry in one cycle: the lookup sees pre-update contents (no bypass). The write lands at the edge.
- Reset asserted mid-operation clears state immediately. Outputs go to 0 / not-valid combinationally.
- No stall or backpressure. Every request is served each cycle.

Optional Feature:
Macro DALLANMA_ISTATISTIK_EN.
- Defined: adds 32-bit outputs tahmin_sayisi_o, atlar_tahmin_sayisi_o, hata_sayisi_o.
  - tahmin_sayisi_o increments per cycle with ongoru_aktif_i=1.
  - atlar_tahmin_sayisi_o increments per cycle with ongoru_gecerli_o=1.
  - hata_sayisi_o increments per cycle with guncelle_gecerli_i and dallanma_hata_i.
  - All saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports and logic are absent. Prediction behaviour is identical.

Test Plan:
1. After reset, ongoru_aktif_i=1, ps_i=0x100 -> ongoru_gecerli_o=0, atlanan_ps_o=0, ongoru_gecmis_o=0x00; GHR stays 0x00.
2. Two updates of PC 0x100, taken, target 0x200, gecmis 0x00 -> PHT counter reaches 2. Then lookup of 0x100 with GHR=0 -> ongoru_gecerli_o=1, atlanan_ps_o=0x200; next GHR=0x01.
3. Five taken updates then one not-taken update to the same uidx -> counter saturates at 3, then 2; lookup still predicts taken. Four further not-taken updates -> counter 0, lookup not taken.
4. GHR=0x5A. Update with dallanma_hata_i=1, gecmis=0x12, atladi=1, plus simultaneous ongoru_aktif_i -> next GHR=0x25, not 0xB4/0xB5.
5. Train 0x100 taken (target 0x200), then taken update of 0x300 (same bidx 0) with target 0x400 -> lookup 0x100 gives ongoru_gecerli_o=0; lookup 0x300 gives 0x400 once its counter MSB=1.
6. Drop rst_i mid-stream, asynchronously between edges -> GHR=0 and ongoru_gecerli_o=0 at once. With DALLANMA_ISTATISTIK_EN defined, 10 lookups with 3 mispredicts give tahmin=10, hata=3, and all counters clear on reset.
